// File: rtl/butterfly_feeder.sv
// Frame buffer and pair scheduler feeding the FFT butterfly: collects `size` complex
// samples, then issues size/2 (a, b, twiddle) operand sets for one stage of span `stride`.
module butterfly_feeder #(
    parameter int n      = 32,
    parameter int d      = 16,
    parameter int size   = 8,
    parameter int stride = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    recv_val,
    output logic                    recv_rdy,
    input  logic [n-1:0]            recv_r,
    input  logic [n-1:0]            recv_c,
    output logic                    send_val,
    input  logic                    send_rdy,
    output logic [n-1:0]            ar,
    output logic [n-1:0]            ac,
    output logic [n-1:0]            br,
    output logic [n-1:0]            bc,
    output logic [n-1:0]            wr,
    output logic [n-1:0]            wc,
    output logic [$clog2(size)-1:0] pair_idx,
    output logic [$clog2(size)-1:0] tw_idx,
    input  logic [n-1:0]            tw_r,
    input  logic [n-1:0]            tw_c
);

    localparam int AW  = $clog2(size);
    localparam int SW  = $clog2(stride);
    localparam int KSH = AW - 1 - SW;
    localparam logic [AW-1:0] MASK    = AW'(stride - 1);
    localparam logic [AW-1:0] SPAN    = AW'(stride);
    localparam logic [AW-1:0] LAST_NP = AW'(size / 2 - 1);
    localparam logic [AW-1:0] LAST_W  = AW'(size - 1);

    if (size < 2 || (size & (size - 1)) != 0) begin : g_bad_size
        $error("butterfly_feeder: size must be a power of two >= 2");
    end
    if (stride < 1 || stride > size / 2 || (stride & (stride - 1)) != 0) begin : g_bad_stride
        $error("butterfly_feeder: stride must be a power of two in 1..size/2");
    end
    if (d < 0 || d >= n) begin : g_bad_frac
        $error("butterfly_feeder: d must lie in 0..n-1");
    end

    typedef enum logic {
        FILL,
        ISSUE
    } state_t;

    state_t          state, state_nx;
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   np;
    logic [n-1:0]    mem_r [size];
    logic [n-1:0]    mem_c [size];

    logic            accept;
    logic            load;
    logic [AW-1:0]   a_idx;
    logic [AW-1:0]   b_idx;
    logic [n-1:0]    a_r, a_c, b_r, b_c;

    // Stride is a power of two, so the div/mod pair mapping reduces to shifts and masks.
    function automatic logic [AW-1:0] pair_a(input logic [AW-1:0] p);
        return ((p >> SW) << (SW + 1)) | (p & MASK);
    endfunction

    function automatic logic [AW-1:0] tw_k(input logic [AW-1:0] p);
        return (p & MASK) << KSH;
    endfunction

    always_comb begin
        state_nx = state;
        recv_rdy = 1'b0;
        send_val = 1'b0;
        accept   = 1'b0;
        load     = 1'b0;
        case (state)
            FILL: begin
                recv_rdy = 1'b1;
                accept   = recv_val;
                if (recv_val && wptr == LAST_W) begin
                    load     = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                send_val = 1'b1;
                // np has already wrapped to 0 once the final pair is on the outputs.
                if (send_rdy) begin
                    if (np == '0) state_nx = FILL;
                    else          load     = 1'b1;
                end
            end
            default: state_nx = FILL;
        endcase
    end

    always_comb begin
        a_idx  = pair_a(np);
        b_idx  = a_idx + SPAN;
        tw_idx = tw_k(np);
        // The final sample is written at the same edge the first pair is loaded.
        a_r = (accept && wptr == a_idx) ? recv_r : mem_r[a_idx];
        a_c = (accept && wptr == a_idx) ? recv_c : mem_c[a_idx];
        b_r = (accept && wptr == b_idx) ? recv_r : mem_r[b_idx];
        b_c = (accept && wptr == b_idx) ? recv_c : mem_c[b_idx];
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_r[wptr] <= recv_r;
            mem_c[wptr] <= recv_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FILL;
            wptr     <= '0;
            np       <= '0;
            ar       <= '0;
            ac       <= '0;
            br       <= '0;
            bc       <= '0;
            wr       <= '0;
            wc       <= '0;
            pair_idx <= '0;
        end else begin
            state <= state_nx;
            if (accept) wptr <= wptr + 1'b1;
            if (load) begin
                ar       <= a_r;
                ac       <= a_c;
                br       <= b_r;
                bc       <= b_c;
                wr       <= tw_r;
                wc       <= tw_c;
                pair_idx <= a_idx;
                np       <= (np == LAST_NP) ? '0 : np + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_butterfly_feeder.sv
// Bench for butterfly_feeder: three instances (stride 1, 2, 4) share one stimulus stream
// and are checked against a frame-level model of the pair/twiddle mapping.
module tb_butterfly_feeder;

    localparam int N  = 32;
    localparam int SZ = 8;
    localparam int NS = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          recv_val;
    logic          send_rdy;
    logic [N-1:0]  recv_r, recv_c;
    logic          recv_rdy [NS];
    logic          send_val [NS];
    logic [N-1:0]  ar [NS], ac [NS], br [NS], bc [NS], wr [NS], wc [NS];
    logic [2:0]    pair_idx [NS], tw_idx [NS];
    logic [N-1:0]  tw_r [NS], tw_c [NS];

    logic [N-1:0]  fr [SZ];
    logic [N-1:0]  fc [SZ];
    int            total = 0;
    int            bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NS; g++) begin : g_dut
        assign tw_r[g] = 32'd100 + 32'(tw_idx[g]);
        assign tw_c[g] = 32'hC000_0000 + 32'(tw_idx[g]) * 32'd7;
        butterfly_feeder #(.n(N), .d(16), .size(SZ), .stride(1 << g)) u_dut (
            .clk(clk), .reset(reset),
            .recv_val(recv_val), .recv_rdy(recv_rdy[g]),
            .recv_r(recv_r), .recv_c(recv_c),
            .send_val(send_val[g]), .send_rdy(send_rdy),
            .ar(ar[g]), .ac(ac[g]), .br(br[g]), .bc(bc[g]),
            .wr(wr[g]), .wc(wc[g]),
            .pair_idx(pair_idx[g]), .tw_idx(tw_idx[g]),
            .tw_r(tw_r[g]), .tw_c(tw_c[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int idx_a(input int s, input int p);
        return (p / s) * 2 * s + (p % s);
    endfunction

    function automatic int idx_k(input int s, input int p);
        return (p % s) * (SZ / (2 * s));
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        for (int g = 0; g < NS; g++) begin
            chk({tag, "_rdy"}, 64'(recv_rdy[g]), 64'd1);
            chk({tag, "_sval"}, 64'(send_val[g]), 64'd0);
            chk({tag, "_twidx"}, 64'(tw_idx[g]), 64'd0);
        end
    endtask

    task automatic check_reset_state();
        check_idle("rst");
        for (int g = 0; g < NS; g++) begin
            chk("rst_ar", 64'(ar[g]), 64'd0);
            chk("rst_bc", 64'(bc[g]), 64'd0);
            chk("rst_wr", 64'(wr[g]), 64'd0);
            chk("rst_wc", 64'(wc[g]), 64'd0);
            chk("rst_pidx", 64'(pair_idx[g]), 64'd0);
        end
    endtask

    // mode 0: back-to-back, 1: alternating 1,0, 2: random gaps
    task automatic fill(input int mode, input bit det);
        int  got    = 0;
        int  cycles = 0;
        bit  v;
        while (got < SZ) begin
            for (int g = 0; g < NS; g++) begin
                chk("fill_rdy", 64'(recv_rdy[g]), 64'd1);
                chk("fill_sval", 64'(send_val[g]), 64'd0);
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = (cycles % 2 == 0);
                default: v = ($urandom_range(0, 1) == 1) || (cycles > 40);
            endcase
            recv_val = v;
            recv_r   = det ? N'(got) : $urandom;
            recv_c   = det ? N'(-got) : $urandom;
            send_rdy = $urandom_range(0, 1) == 1;
            if (v) begin
                fr[got] = recv_r;
                fc[got] = recv_c;
                got++;
            end
            cycles++;
            cyc();
        end
        recv_val = 1'b0;
        recv_r   = $urandom;
        recv_c   = $urandom;
    endtask

    // bp_pair >= 0: hold send_rdy low bp_len cycles on that pair; -1: random; -2: always ready
    task automatic issue(input int bp_pair, input int bp_len, input int npairs);
        int p    = 0;
        int hold = 0;
        bit r;
        while (p < npairs) begin
            for (int g = 0; g < NS; g++) begin
                int s = 1 << g;
                int a = idx_a(s, p);
                int k = idx_k(s, p);
                chk("iss_sval", 64'(send_val[g]), 64'd1);
                chk("iss_rdy", 64'(recv_rdy[g]), 64'd0);
                chk("iss_pidx", 64'(pair_idx[g]), 64'(a));
                chk("iss_ar", 64'(ar[g]), 64'(fr[a]));
                chk("iss_ac", 64'(ac[g]), 64'(fc[a]));
                chk("iss_br", 64'(br[g]), 64'(fr[a + s]));
                chk("iss_bc", 64'(bc[g]), 64'(fc[a + s]));
                chk("iss_wr", 64'(wr[g]), 64'(100 + k));
                chk("iss_wc", 64'(wc[g]), 64'(32'hC000_0000 + 32'(k * 7)));
                chk("iss_twidx", 64'(tw_idx[g]), 64'(idx_k(s, (p + 1) % (SZ / 2))));
            end
            if (bp_pair >= 0 && p == bp_pair && hold < bp_len) begin
                r = 1'b0;
                hold++;
            end else if (bp_pair == -1) begin
                r = $urandom_range(0, 3) != 0;
            end else begin
                r = 1'b1;
            end
            send_rdy = r;
            recv_val = $urandom_range(0, 1) == 1;
            cyc();
            if (r) p++;
        end
        send_rdy = 1'b0;
        recv_val = 1'b0;
        if (npairs == SZ / 2) check_idle("done");
    endtask

    task automatic async_reset();
        reset    = 1'b1;
        recv_val = 1'b0;
        send_rdy = 1'b0;
        #1;
        check_reset_state();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        recv_val = 1'b0;
        send_rdy = 1'b0;
        recv_r   = '0;
        recv_c   = '0;
        #1;
        check_reset_state();
        @(negedge clk);
        reset = 1'b0;

        fill(0, 1'b1);
        issue(-2, 0, SZ / 2);

        fill(0, 1'b0);
        issue(1, 3, SZ / 2);

        fill(1, 1'b0);
        issue(-1, 0, SZ / 2);

        for (int i = 0; i < 3; i++) begin
            recv_val = 1'b1;
            recv_r   = $urandom;
            recv_c   = $urandom;
            cyc();
        end
        async_reset();
        fill(2, 1'b0);
        issue(-2, 0, 2);
        async_reset();
        fill(0, 1'b0);
        issue(-2, 0, SZ / 2);

        for (int f = 0; f < 20; f++) begin
            fill(2, 1'b0);
            issue(-1, 0, SZ / 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/butterfly_feeder.md
# butterfly_feeder

Frame buffer and pair scheduler that sits directly upstream of the butterfly unit in the FFT datapath. It collects a frame of `size` complex samples arriving serially, then issues `size/2` butterfly operand sets (a, b, twiddle w) for one FFT stage of a given `stride`, one set per accepted handshake. It fetches twiddles from an external combinational ROM through an index port.

## Interface
- `n`, 32, total fixed-point word width (matches butterfly `n`)
- `d`, 16, fractional bits. Pass-through only; the block does no arithmetic on data.
- `size`, 8, frame length; power of two, ≥ 2
- `stride`, 1, butterfly span; power of two, 1 ≤ stride ≤ size/2
- `clk`  in  1  clock. One clock domain; all state changes on its rising edge.
- `reset`  in  1  reset, asynchronous, active-high
- `recv_val`  in  1  input sample valid
- `recv_rdy`  out  1  block can accept a sample
- `recv_r`, `recv_c`  in  n  input sample, real/imag
- `send_val`  out  1  operand set valid
- `send_rdy`  in  1  butterfly accepts operand set
- `ar`, `ac`, `br`, `bc`  out  n  operands a and b, real/imag
- `wr`, `wc`  out  n  twiddle, real/imag
- `pair_idx`  out  log2(size)  index i of operand a; b is i+stride
- `tw_idx`  out  log2(size)  twiddle ROM address for the pair being loaded next
- `tw_r`, `tw_c`  in  n  ROM data; combinational function of `tw_idx`

## Operation
- Internal storage: buffer of `size` complex words, write pointer `wptr`, next-pair counter `np` (0..size/2-1), and state FILL/ISSUE.
- Pair mapping for counter p:
  - i = (p / stride)·2·stride + (p mod stride); b index = i + stride.
  - twiddle index k = (p mod stride)·(size/(2·stride)).
  - `tw_idx` = k(np) at all times. During FILL np = 0, so `tw_idx` = 0.
- FILL:
  - `recv_rdy`=1, `send_val`=0.
  - On recv_val&recv_rdy: buf[wptr] ← (recv_r, recv_c); wptr++.
  - On accepting the sample with wptr = size-1, at the same edge:
    - load the output registers with pair np=0: ar/ac ← buf[i]; br/bc ← buf[i+stride], using the sample being written if it is one of them;
    - wr/wc ← tw_r/tw_c;
    - pair_idx ← i; np ← 1; wptr ← 0;
    - `send_val` ← 1, `recv_rdy` ← 0; state → ISSUE.
- ISSUE:
  - `recv_rdy`=0. Outputs hold stable while send_val=1 and send_rdy=0.
  - On send_val&send_rdy with pairs remaining: load pair np as above, np++, send_val stays 1.
  - On handshake of the last pair (p = size/2-1): send_val ← 0, recv_rdy ← 1, np ← 0, state → FILL.
- Data is copied bit-exact; no rounding, scaling or sign handling. `d` does not affect behaviour.

## Timing
- Reset (async, immediate):
  - state FILL, wptr=0, np=0;
  - recv_rdy=1, send_val=0;
  - ar/ac/br/bc/wr/wc=0, pair_idx=0, tw_idx=0.
  - Buffer contents are don't-care.
- Input accepts one sample per cycle. A gap in recv_val stalls the fill with no loss.
- First operand set is valid the cycle after the last sample is accepted.
- With send_rdy held high, pairs issue one per cycle: size/2 cycles.
- recv_rdy rises the cycle after the last pair handshake.
- Minimum frame period is size + size/2 cycles. There is no overlap of fill and issue.
- Reset asserted mid-fill or mid-issue aborts the frame. The partial frame is discarded, and operation restarts with wptr=0 after reset deasserts.
- `tw_r`/`tw_c` are sampled only at pair-load edges. The ROM needs no latency beyond combinational.

## Test plan
- size=8, stride=1; input k+j(−k) for k=0..7; send_rdy=1 → pairs (0,1),(2,3),(4,5),(6,7) on 4 consecutive cycles; ar=0,2,4,6; br=1,3,5,7; tw_idx=0 throughout; recv_rdy=1 one cycle after pair 3.
- size=8, stride=4; ROM returns tw_r=100+idx → pair_idx 0,1,2,3; br=4,5,6,7; tw_idx/wr = 0/100, 1/101, 2/102, 3/103.
- size=8, stride=2 → pair_idx 0,1,4,5; b indices 2,3,6,7; twiddle idx 0,2,0,2.
- Backpressure: send_rdy low for 3 cycles on pair 1 → outputs and send_val held constant; recv_rdy stays 0; no pair skipped or duplicated.
- Gapped input: recv_val toggling 1,0,1,0 over 16 cycles → exactly 8 samples stored; first set valid the cycle after the 8th accept.
- Reset asserted after 2 pairs issued → send_val=0 and recv_rdy=1 immediately. A fresh frame then issues from pair 0 with new data only.
